// File: rtl/regset_pkg.sv
// Shared sizes and writeback requester indices for the register set.
// Latency: none (constants only).
// Backpressure: not applicable.
package regset_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;
  localparam int WB_N_REQ   = 3;

  // Writeback requester slots
  localparam int WB_ALU = 0;
  localparam int WB_MEM = 1;
  localparam int WB_MUL = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant among N requesters with a rotating priority pointer.
// Latency: grant is combinational from req; the pointer moves at the next edge.
// Backpressure: ungranted requesters hold; the pointer moves only on advance.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         CLK,
  input  logic         RES,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next_ptr;
  logic          w_found;

  // First active request at or above the pointer wins, otherwise wrap to the bottom
  always_comb begin
    grant      = '0;
    w_found    = 1'b0;
    w_next_ptr = r_ptr;
    for (int i = 0; i < N; i++) begin
      if (!w_found && req[i] && (i >= int'(r_ptr))) begin
        w_found    = 1'b1;
        grant[i]   = 1'b1;
        w_next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && req[i] && (i < int'(r_ptr))) begin
        w_found    = 1'b1;
        grant[i]   = 1'b1;
        w_next_ptr = (i == N - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  // Move priority just past the requester that transferred
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/regset_wb_arbiter.sv
// Shares the register-set write port among writeback requesters; tracks pending writes.
// Latency: one cycle from a granted transfer to D/A_D/write_enable.
// Backpressure: one grant per cycle via req_ready; issue refused by stall_issue on WAW.
module regset_wb_arbiter
  import regset_pkg::*;
#(
  parameter int N_REQ  = WB_N_REQ,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                    CLK,
  input  logic                    RES,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    issue_valid,
  input  logic [ADDR_W-1:0]       issue_addr,
  output logic                    stall_issue,
  input  logic [ADDR_W-1:0]       A_Q0,
  input  logic [ADDR_W-1:0]       A_Q1,
  output logic                    hazard0,
  output logic                    hazard1,
  output logic [DATA_W-1:0]       D,
  output logic [ADDR_W-1:0]       A_D,
  output logic                    write_enable
);

  localparam int NREG = 2 ** ADDR_W;

  logic [N_REQ-1:0]  w_grant;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_xfer_addr;
  logic [DATA_W-1:0] w_xfer_data;
  logic              w_set;
  logic [NREG-1:0]   r_busy;
  logic [DATA_W-1:0] r_d;
  logic [ADDR_W-1:0] r_ad;
  logic              r_we;

  rr_arbiter #(
    .N (N_REQ)
  ) u_rr (
    .CLK     (CLK),
    .RES     (RES),
    .req     (req_valid),
    .advance (w_xfer),
    .grant   (w_grant)
  );

  // A grant is only ever given to a valid requester, so any grant is a transfer
  assign req_ready = w_grant;
  assign w_xfer    = |w_grant;

  // Pick the address/data slice of the granted requester
  always_comb begin
    w_xfer_addr = '0;
    w_xfer_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_xfer_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_xfer_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Stall looks only at registered busy, so a same-cycle writeback does not unblock issue
  assign stall_issue = issue_valid && r_busy[issue_addr] && (issue_addr != '0);
  assign w_set       = issue_valid && !stall_issue && (issue_addr != '0);

  // Pending-write scoreboard: clear on writeback, then set on issue so a new writer wins
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_busy <= '0;
    end else begin
      if (w_xfer) begin
        r_busy[w_xfer_addr] <= 1'b0;
      end
      if (w_set) begin
        r_busy[issue_addr] <= 1'b1;
      end
      r_busy[0] <= 1'b0;
    end
  end

  // Register the granted write; address 0 consumes the slot but never strobes
  always_ff @(posedge CLK) begin
    if (RES) begin
      r_d  <= '0;
      r_ad <= '0;
      r_we <= 1'b0;
    end else if (w_xfer) begin
      r_d  <= w_xfer_data;
      r_ad <= w_xfer_addr;
      r_we <= (w_xfer_addr != '0);
    end else begin
      r_we <= 1'b0;
    end
  end

  assign D            = r_d;
  assign A_D          = r_ad;
  assign write_enable = r_we;

  // A read is stale while its register is pending or is being written this cycle
  assign hazard0 = (A_Q0 != '0) && (r_busy[A_Q0] || (r_we && (r_ad == A_Q0)));
  assign hazard1 = (A_Q1 != '0) && (r_busy[A_Q1] || (r_we && (r_ad == A_Q1)));

endmodule

// File: doc/regset_wb_arbiter.md
Name: regset_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register set between N_REQ writeback requesters (ALU, load unit, multiplier) using round-robin arbitration.
- Keeps a 32-entry pending-write scoreboard, set at issue and cleared at writeback.
- Reports read-after-write hazards for the two read addresses, and stalls issue on write-after-write conflicts.
- Sits between the execute/writeback stage and the register set. Its D/A_D/write_enable outputs drive the register set directly.

Parameters:
- N_REQ, 3, number of writeback requesters (2..8).
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width (2**ADDR_W registers; register 0 hardwired zero).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RES  in  1  synchronous active-high reset.
- req_valid  in  N_REQ  requester i has a result.
- req_ready  out  N_REQ  grant to requester i, one-hot or zero, combinational.
- req_addr  in  N_REQ*ADDR_W  destination register, slice i.
- req_data  in  N_REQ*DATA_W  result data, slice i.
- issue_valid  in  1  an instruction with destination issue_addr is issuing.
- issue_addr  in  ADDR_W  destination of the issuing instruction.
- stall_issue  out  1  issue refused this cycle (WAW conflict).
- A_Q0, A_Q1  in  ADDR_W  read addresses under hazard check.
- hazard0, hazard1  out  1  read of A_Q0 / A_Q1 would return stale data.
- D  out  DATA_W  write data to register set.
- A_D  out  ADDR_W  write address to register set.
- write_enable  out  1  write strobe to register set.

Behaviour:
- Reset (RES=1 at edge):
  - busy[31:0]=0, rr pointer=0.
  - write_enable=0, D=0, A_D=0.
  - Requests and issue presented in the reset cycle are discarded.
  - Reset mid-operation drops all pending writes.
- Arbitration (combinational):
  - Grant the first i with req_valid[i], searching ptr, ptr+1, ... mod N_REQ.
  - req_ready[i] = grant[i]. Transfer occurs when req_valid[i] & req_ready[i].
  - Requesters hold valid/addr/data stable until ready.
- Pointer: after a transfer by i, ptr <= (i+1) mod N_REQ. Without a transfer, ptr holds.
- Output register, latency 1:
  - On transfer in cycle t, at edge t+1: D<=data_i, A_D<=addr_i, write_enable<=(addr_i!=0).
  - With no transfer: write_enable<=0; D and A_D hold.
  - The register set commits the write at edge t+2.
- Scoreboard:
  - Set: busy[issue_addr]<=1 at the edge when issue_valid & !stall_issue & issue_addr!=0.
  - Clear: busy[addr_i]<=0 at the edge when requester i transfers.
  - Same edge, same address, set and clear: set wins (new writer pending).
  - busy[0] is always 0.
- stall_issue = issue_valid & busy[issue_addr] & (issue_addr!=0). This is combinational and ignores a same-cycle clear.
- hazard0 = (A_Q0!=0) & (busy[A_Q0] | (write_enable & A_D==A_Q0)). hazard1 is identical with A_Q1.
- A transfer to an address that is not busy is still written. The scoreboard is advisory and its clear is idempotent.
- A transfer with addr 0 is accepted and consumes a grant, but produces no write.

Decomposition:
- Package regset_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_COUNT=32, WB_N_REQ=3.
  - Requester index constants: WB_ALU=0, WB_MEM=1, WB_MUL=2.
- One sub-module, rr_arbiter:
  - Parameterised N.
  - Ports: CLK, RES, req[N], advance, grant[N].
  - Contains the pointer and the rotate/priority logic.
- Scoreboard, output register and hazard logic stay in regset_wb_arbiter.

Test Plan:
- Reset: assert RES with all req_valid=1 and issue_valid=1 (addr 7) -> next cycle write_enable=0, D=0, A_D=0, hazard0=0 for A_Q0=7, ptr=0.
- Single writer:
  - Issue addr 5, then req0 valid with addr 5, data 0xDEADBEEF, two cycles later.
  - Expected: hazard0=1 (A_Q0=5) from the cycle after issue through the cycle with write_enable=1.
  - Next cycle write_enable=1, A_D=5, D=0xDEADBEEF. One cycle later hazard0=0.
- Round-robin: req0, req1 and req2 all valid continuously with addrs 1, 2, 3 -> grants in order 0,1,2,0,1,2; A_D sequence 1,2,3,1,2,3 with write_enable=1 every cycle.
- WAW stall: busy[9]=1, issue addr 9 -> stall_issue=1 and busy unchanged. The same cycle req1 writes addr 9; issue retried the next cycle -> stall_issue=0, busy[9]=1.
- Simultaneous set/clear: issue addr 4 (retry case) on the same edge as requester 2 transfers addr 4 -> busy[4]=1 afterward, hazard1=1 for A_Q1=4.
- Register 0: issue addr 0 -> stall_issue=0, no busy. req0 addr 0, data 0x1234 -> req_ready[0]=1, next cycle write_enable=0, hazard0=0 for A_Q0=0.
